result_streamer: RTL and testbench

//  Downstream drain stage of the matrix multiplier. On a rising edge of result_ready it reads the

---
 rtl/result_streamer.sv | 231 +++++++++++++++++++++++
 tb/tb_result_streamer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_streamer.sv
// -----------------------------------------------------------------------------
// result_streamer
//
// Drain stage of the matrix multiplier. A rising edge on result_ready starts a
// read of the result matrix from memory port B. The read order is header rows,
// then header cols, then the elements in row-major order. The elements go out
// as a valid/ready word stream, and out_last marks the final element. A
// 2-entry prefetch buffer hides the 1-cycle memory read latency and absorbs
// backpressure.
//
// Optional build macro:
//   STREAM_HEADER_EN - emit rows and cols as two header beats ahead of the
//                      elements. An empty matrix then still produces the two
//                      header beats, with out_last on the cols beat.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   result_ready  in   multiplier done flag; a 0->1 edge starts a drain
//   mem_addr      out  read address to memory port B (held while idle)
//   mem_q         in   memory read data, valid 1 cycle after mem_addr
//   out_data      out  stream word (head of the prefetch buffer)
//   out_valid     out  out_data is valid
//   out_ready     in   sink accepts when out_valid & out_ready
//   out_last      out  final beat of the matrix
//   busy          out  drain in progress, from start edge through done cycle
//   done          out  1-cycle pulse after the final beat, or on empty/error
//   dim_error     out  sticky rows/cols > MAX_LEN flag, cleared on next start
// -----------------------------------------------------------------------------
module result_streamer #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 12,
   parameter int          MAX_LEN     = 100,
   parameter int          MAX_LEN_LOG = 7,
   parameter int unsigned RESULT_BASE = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  result_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  dim_error
);

   localparam int TW = 2 * MAX_LEN_LOG;   // width of rows*cols
   localparam int CW = TW + 1;            // item counter, room for header beats
   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(RESULT_BASE);
   localparam logic [DATA_WIDTH-1:0] MAX_D  = DATA_WIDTH'(MAX_LEN);

`ifdef STREAM_HEADER_EN
   localparam logic [CW-1:0] HDR_ITEMS = CW'(2);
`else
   localparam logic [CW-1:0] HDR_ITEMS = '0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ROWS, S_RD_COLS, S_CHECK, S_STREAM, S_FLUSH
   } state_t;

   state_t                  state_q;
   logic                    rr_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    dim_err_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   rows_q;
   logic [DATA_WIDTH-1:0]   cols_q;
   logic [CW-1:0]           n_items_q;
   logic [CW-1:0]           cnt_q;

   // Read-return stage: p1_q marks that mem_q carries an item issued last cycle.
   // Header items bypass memory and carry their word in p1_hword_q.
   logic                    p1_q;
   logic                    p1_last_q;
   logic                    p1_hdr_q;
   logic [DATA_WIDTH-1:0]   p1_hword_q;

   // Prefetch buffer, entry 0 is the head.
   logic [DATA_WIDTH-1:0]   buf_data_q [2];
   logic                    buf_last_q [2];
   logic [1:0]              occ_q;

   logic                    pop;
   logic                    push;
   logic [DATA_WIDTH-1:0]   push_data;
   logic [2:0]              credit;
   logic                    issue;
   logic [1:0]              occ_d;
   logic [1:0]              wr_pos;
   logic                    start;
   logic                    last_item;
   logic                    item_is_hdr;
   logic [DATA_WIDTH-1:0]   hdr_word;
   logic                    dims_bad;
   logic [TW-1:0]           total_w;
   logic [CW-1:0]           n_items_w;

   always_comb begin
      pop       = (occ_q != 2'd0) && out_ready;
      push      = p1_q;
      push_data = p1_hdr_q ? p1_hword_q : mem_q;
      // Count after this cycle's pop. This keeps occupancy plus the returning
      // read at or below 2, and still allows one beat per cycle.
      credit    = 3'({1'b0, occ_q}) - 3'(pop) + 3'(p1_q);
      issue     = (state_q == S_STREAM) && (credit < 3'd2);
      occ_d     = occ_q - 2'(pop) + 2'(push);
      wr_pos    = occ_q - 2'(pop);
      start     = result_ready && !rr_q && !busy_q && (state_q == S_IDLE);
      last_item = (cnt_q == n_items_q - CW'(1));
`ifdef STREAM_HEADER_EN
      item_is_hdr = (cnt_q < HDR_ITEMS);
`else
      item_is_hdr = 1'b0;
`endif
      hdr_word  = (cnt_q == '0) ? rows_q : cols_q;
      // In CHECK, mem_q holds the cols word.
      dims_bad  = (rows_q > MAX_D) || (mem_q > MAX_D);
      total_w   = TW'(rows_q[MAX_LEN_LOG-1:0]) * TW'(mem_q[MAX_LEN_LOG-1:0]);
      n_items_w = CW'(total_w) + HDR_ITEMS;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rr_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         dim_err_q     <= 1'b0;
         mem_addr_q    <= '0;
         rows_q        <= '0;
         cols_q        <= '0;
         n_items_q     <= '0;
         cnt_q         <= '0;
         p1_q          <= 1'b0;
         p1_last_q     <= 1'b0;
         p1_hdr_q      <= 1'b0;
         p1_hword_q    <= '0;
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
         buf_last_q[0] <= 1'b0;
         buf_last_q[1] <= 1'b0;
         occ_q         <= 2'd0;
      end else begin
         rr_q   <= result_ready;
         done_q <= 1'b0;

         // Buffer: shift the head out on pop, then write the returning item
         // into the first free slot that remains after the pop.
         if (pop) begin
            buf_data_q[0] <= buf_data_q[1];
            buf_last_q[0] <= buf_last_q[1];
         end
         if (push) begin
            buf_data_q[wr_pos[0]] <= push_data;
            buf_last_q[wr_pos[0]] <= p1_last_q;
         end
         occ_q <= occ_d;

         p1_q <= issue;
         if (issue) begin
            p1_last_q  <= last_item;
            p1_hdr_q   <= item_is_hdr;
            p1_hword_q <= hdr_word;
            cnt_q      <= cnt_q + CW'(1);
            if (!item_is_hdr) mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
         end

         case (state_q)
            S_IDLE: begin
               // busy stays high through the cycle that carries done
               busy_q <= 1'b0;
               if (start) begin
                  busy_q     <= 1'b1;
                  dim_err_q  <= 1'b0;
                  mem_addr_q <= BASE_A;
                  state_q    <= S_RD_ROWS;
               end
            end
            S_RD_ROWS: begin
               mem_addr_q <= BASE_A + ADDR_WIDTH'(1);
               state_q    <= S_RD_COLS;
            end
            S_RD_COLS: begin
               rows_q  <= mem_q;
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               cols_q     <= mem_q;
               cnt_q      <= '0;
               n_items_q  <= n_items_w;
               mem_addr_q <= BASE_A + ADDR_WIDTH'(2);
               if (dims_bad) begin
                  dim_err_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_IDLE;
               end else if (n_items_w == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (issue && last_item) state_q <= S_FLUSH;
            end
            S_FLUSH: begin
               if (pop && buf_last_q[0]) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign out_data  = buf_data_q[0];
   assign out_valid = (occ_q != 2'd0);
   assign out_last  = (occ_q != 2'd0) && buf_last_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign dim_error = dim_err_q;

endmodule

// File: tb/tb_result_streamer.sv
module tb_result_streamer;

   localparam int DW = 32;
   localparam int AW = 12;

`ifdef STREAM_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          result_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_q;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          dim_error;

   logic [DW-1:0] mem [0:4095];
   int            checks = 0;
   int            errors = 0;

   logic [DW-1:0] bq[$];
   int            lastpos, lastcnt, first_cyc, last_cyc, done_cyc;

   result_streamer dut (
      .clk          (clk),
      .reset        (reset),
      .result_ready (result_ready),
      .mem_addr     (mem_addr),
      .mem_q        (mem_q),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .dim_error    (dim_error)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data appears one cycle after the address.
   always @(posedge clk) mem_q <= mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_case1();
      mem[0] = 32'd2;
      mem[1] = 32'd3;
      for (int k = 0; k < 6; k++) mem[2 + k] = 32'(k + 1);
   endtask

   task automatic start(input bit hold);
      @(negedge clk);
      result_ready = 1'b1;
      @(negedge clk);
      if (!hold) result_ready = 1'b0;
      chk("start_busy", busy, 1);
   endtask

   // rmode 0: out_ready always high; rmode 1: ready pattern 1,0,0 repeating.
   task automatic drain(input int rmode, input int budget);
      bit            ok, prev_stall, prev_last;
      logic [DW-1:0] prev_data;
      ok = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
      bq.delete();
      lastpos = -1; lastcnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         out_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
         end
         if (done) begin
            done_cyc = cyc;
            ok = 1;
            break;
         end
         if (out_valid && out_ready) begin
            bq.push_back(out_data);
            if (out_last) begin
               lastcnt++;
               lastpos = bq.size() - 1;
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
      if (!ok) chk("drain_timeout", 0, 1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("done_pulse_len", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   // Expected stream from the bench's own memory image and dimensions.
   task automatic check_stream(input int r, input int c, input bit err, input bit agg);
      logic [DW-1:0] exp[$];
      int bad;
      if (!err) begin
         if (HDR) begin
            exp.push_back(DW'(r));
            exp.push_back(DW'(c));
         end
         for (int k = 0; k < r * c; k++) exp.push_back(mem[(2 + k) % 4096]);
      end
      chk("n_beats", bq.size(), exp.size());
      bad = 0;
      for (int i = 0; i < bq.size() && i < exp.size(); i++) begin
         if (agg) begin
            if (bq[i] !== exp[i]) bad++;
         end else begin
            chk($sformatf("beat%0d", i), bq[i], exp[i]);
         end
      end
      if (agg) chk("beats_bad", bad, 0);
      chk("last_pos", lastpos, exp.size() - 1);
      chk("last_cnt", lastcnt, (exp.size() > 0) ? 1 : 0);
   endtask

   initial begin
      int  n;
      bit  seen;
      for (int a = 0; a < 4096; a++) mem[a] = '0;
      reset = 1'b1; result_ready = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dimerr", dim_error, 0);
      chk("rst_addr", mem_addr, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: 2x3, full throughput
      load_case1();
      start(0);
      drain(0, 100);
      check_stream(2, 3, 0, 0);
      chk("consecutive", last_cyc - first_cyc, HDR ? 7 : 5);
      chk("done_after_last", done_cyc, last_cyc + 1);

      // 2: same matrix under backpressure
      start(0);
      drain(1, 200);
      check_stream(2, 3, 0, 0);

      // 3: empty matrix and dimension error
      mem[0] = 32'd0; mem[1] = 32'd5;
      start(0);
      drain(0, 50);
      check_stream(0, 5, 0, 0);
      chk("empty_dimerr", dim_error, 0);

      mem[0] = 32'd101; mem[1] = 32'd1;
      start(0);
      drain(0, 50);
      check_stream(101, 1, 1, 0);
      chk("dimerr_set", dim_error, 1);

      load_case1();
      start(0);
      chk("dimerr_clear", dim_error, 0);
      drain(0, 100);
      check_stream(2, 3, 0, 0);

      // 0x0 matrix
      mem[0] = 32'd0; mem[1] = 32'd0;
      start(0);
      drain(0, 50);
      check_stream(0, 0, 0, 0);

      // 5: reset after the third beat, then a full replay
      load_case1();
      start(0);
      out_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
         @(negedge clk);
         if (out_valid && out_ready) n++;
      end
      chk("pre_reset_beats", n, 3);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_addr", mem_addr, 0);
      @(negedge clk);
      reset = 1'b0;
      start(0);
      drain(0, 100);
      check_stream(2, 3, 0, 0);

      // Level-high result_ready starts only one drain
      start(1);
      drain(0, 100);
      check_stream(2, 3, 0, 0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy || out_valid) seen = 1;
      end
      chk("hold_no_restart", seen, 0);
      result_ready = 1'b0;

      // 4: 100x100 with address-pattern data (addresses wrap at 4096)
      for (int a = 2; a < 4096; a++) mem[a] = 32'hA500_0000 | a;
      mem[0] = 32'd100; mem[1] = 32'd100;
      start(0);
      drain(0, 12000);
      check_stream(100, 100, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
